audio_pwm: RTL
==============

AUDIO_PWM -- requirements
Module: audio_pwm

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, giving the sample and duty width; the PWM frame is 2^PWM_BITS clocks.
REQ-002 SHALL have port clk  input  1  system clock; all state is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port sample_in  input  PWM_BITS  unsigned sample from the filter stage (midscale 0x80).
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-006 SHALL have port mute  input  1  level; forces output toward midscale.
REQ-007 SHALL have port overrun_clr  input  1  one-cycle strobe clearing overrun.
REQ-008 SHALL have port pwm_out  output  1  registered PWM bit to the external RC DAC.
REQ-009 SHALL have port frame_strobe  output  1  one-cycle pulse on every frame boundary.
REQ-010 SHALL have port overrun  output  1  sticky flag: a pending sample was overwritten.

Function
REQ-011 SHALL run a free-running frame counter cnt, 0 to 2^PWM_BITS-1, wrapping to 0; the boundary is the cycle with cnt = max.
REQ-012 SHALL drive pwm_out as the registered value of (cnt < duty), giving one clock of latency versus cnt.
  - duty 0x00 gives 0 high clocks per frame.
  - duty 0xFF gives 255 high clocks per frame.
REQ-013 SHALL capture sample_in into a pending register on sample_valid and set pending_full.
REQ-014 SHALL, on sample_valid with pending_full=1 and no boundary that cycle, overwrite pending and set overrun.
REQ-015 SHALL, at a boundary with mute=0 and pending_full=1, load duty from pending and clear pending_full.
REQ-016 SHALL, at a boundary with pending_full=0 and mute=0, hold duty unchanged (repeat last sample).
REQ-017 SHALL, when sample_valid coincides with a boundary, resolve in this order:
  - old pending goes to duty;
  - new sample becomes pending, with pending_full=1;
  - overrun is not set.
REQ-018 SHALL assert frame_strobe for exactly the cycle after the boundary, i.e. the cycle where cnt = 0.
REQ-019 SHALL clear overrun on overrun_clr; a simultaneous set wins over the clear.
REQ-020 SHALL, at a boundary with mute=1, discard pending (clear pending_full); duty then behaves per the Configuration section.
REQ-021 SHALL change duty only at boundaries, so no frame is ever truncated.

Reset
REQ-022 SHALL, while rst=1, force the following values:
  - cnt = 0;
  - duty = 0x80;
  - pending = 0x80;
  - pending_full = 0;
  - pwm_out = 0;
  - frame_strobe = 0;
  - overrun = 0.
REQ-023 SHALL resume with frame 0 at cnt=0 on the first clock after rst deasserts, even if rst asserted mid-frame.

Configuration
REQ-024 SHALL support macro AUDIO_PWM_SOFT_MUTE_EN.
REQ-025 With AUDIO_PWM_SOFT_MUTE_EN defined, a muted boundary SHALL step duty by 1 toward 0x80 and hold once duty equals 0x80.
REQ-026 With AUDIO_PWM_SOFT_MUTE_EN defined, unmuting SHALL load the next pending sample directly, with no ramp up.
REQ-027 Without AUDIO_PWM_SOFT_MUTE_EN, a muted boundary SHALL set duty = 0x80 immediately.

Structure
REQ-028 SHALL place PWM_BITS default, MIDSCALE (0x80) and the frame-length constant in the shared audio package.
REQ-029 SHALL be a single module; the optional mute ramp SHALL be an inline always block, not a sub-module.

Verification
REQ-030 Bench SHALL check reset: hold rst mid-frame, then release -> pwm_out=0, overrun=0, first frame_strobe 256 clocks after release, frame of 128 high clocks.
REQ-031 Bench SHALL check duty extremes: samples 0x00, 0x40, 0xFF, one per frame -> high counts 0, 64, 255 in successive frames after load.
REQ-032 Bench SHALL check overrun: two sample_valid strobes (0x10, 0x20) within one frame -> overrun=1, next frame high count 32; overrun_clr -> 0.
REQ-033 Bench SHALL check boundary coincidence: pending 0x30, sample_valid 0x50 on the cnt=255 cycle -> frame of 48 high, next frame 80 high, overrun=0.
REQ-034 Bench SHALL check soft mute (macro on): duty 0x84, assert mute -> frames of 131, 130, 129, 128, 128 high.
REQ-035 Bench SHALL check hard mute (macro off): same stimulus as REQ-034 -> next frame 128 high.

Source files
------------

// File: rtl/audio_pwm_pkg.sv
// Shared constants for the audio PWM DAC driver.
// PWM_BITS_DEF is the default sample/duty width, MIDSCALE the silent-output
// code at that width, FRAME_LEN the number of clocks in one PWM frame.
package audio_pwm_pkg;

  localparam int         PWM_BITS_DEF = 8;
  localparam logic [7:0] MIDSCALE     = 8'h80;
  localparam int         FRAME_LEN    = 1 << PWM_BITS_DEF;

endpackage

// File: rtl/audio_pwm.sv
// Audio PWM DAC driver: free-running frame counter, a one-deep pending
// sample register, and a duty register that only changes on frame
// boundaries so every frame is output complete.
// Optional feature: define AUDIO_PWM_SOFT_MUTE_EN to make mute ramp the
// duty toward midscale by one code per frame instead of jumping there.
module audio_pwm
  import audio_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                mute,
  input  logic                overrun_clr,
  output logic                pwm_out,
  output logic                frame_strobe,
  output logic                overrun
);

  // Midscale at the configured width (0x80 for the default 8 bits).
  localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic                pwm_out_q, pwm_out_d;
  logic                frame_strobe_q, frame_strobe_d;
  logic                overrun_q, overrun_d;
  logic                boundary;

  // Frame counter wraps naturally; the last count of a frame is the boundary.
  always_comb begin
    cnt_d    = cnt_q + ONE;
    boundary = (cnt_q == {PWM_BITS{1'b1}});
  end

  // Pending sample capture; a boundary empties the slot before a coincident
  // new sample refills it, so that case is never an overrun.
  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    overrun_d      = overrun_q;
    if (boundary) begin
      pending_full_d = 1'b0;
    end
    if (sample_valid) begin
      pending_d      = sample_in;
      pending_full_d = 1'b1;
    end
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (sample_valid && pending_full_q && !boundary) begin
      overrun_d = 1'b1;
    end
  end

  // Duty update at boundaries only; mute overrides the pending sample.
  always_comb begin
    duty_d = duty_q;
    if (boundary) begin
      if (mute) begin
`ifdef AUDIO_PWM_SOFT_MUTE_EN
        if (duty_q > MID) begin
          duty_d = duty_q - ONE;
        end else if (duty_q < MID) begin
          duty_d = duty_q + ONE;
        end
`else
        duty_d = MID;
`endif
      end else if (pending_full_q) begin
        duty_d = pending_q;
      end
    end
  end

  // Output bits: compare against the current count, strobe after the boundary.
  always_comb begin
    pwm_out_d      = (cnt_q < duty_q);
    frame_strobe_d = boundary;
  end

  // State registers; reset restarts a fresh frame at midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      duty_q         <= MID;
      pending_q      <= MID;
      pending_full_q <= 1'b0;
      pwm_out_q      <= 1'b0;
      frame_strobe_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_out_q      <= pwm_out_d;
      frame_strobe_q <= frame_strobe_d;
      overrun_q      <= overrun_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign frame_strobe = frame_strobe_q;
  assign overrun      = overrun_q;

endmodule
